// File: rtl/seg7_mux_n.sv
// Time-multiplexed seven-segment driver for DIGITS common-anode digits.
// It provides hex decode, per-digit decimal points, leading-zero suppression, blinking and an anti-ghosting guard.
module seg7_mux_n #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_DIV = 100_000,
  parameter int GUARD       = 16,
  parameter int BLINK_DIV   = 50_000_000
) (
  input  logic                  clk_100MHz,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   digits,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
  output logic [0:6]            seg,
  output logic                  dp,
  output logic [DIGITS-1:0]     an
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [RW-1:0] R_LAST = RW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
  localparam logic [SW-1:0] S_LAST = SW'(DIGITS - 1);

  logic [RW-1:0]     rcnt_r;
  logic [SW-1:0]     s_r;
  logic [BW-1:0]     bcnt_r;
  logic              phase_r;
  logic [DIGITS-1:0] sel_s;
  logic [DIGITS-1:0] nzd_s;
  logic [DIGITS-1:0] lz_s;
  logic [3:0]        nib_s;
  logic              dpi_s;
  logic              guard_s;
  logic              blank_s;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    case (nib)
      4'h0:    hex_to_seg = 7'b0000001;
      4'h1:    hex_to_seg = 7'b1001111;
      4'h2:    hex_to_seg = 7'b0010010;
      4'h3:    hex_to_seg = 7'b0000110;
      4'h4:    hex_to_seg = 7'b1001100;
      4'h5:    hex_to_seg = 7'b0100100;
      4'h6:    hex_to_seg = 7'b0100000;
      4'h7:    hex_to_seg = 7'b0001111;
      4'h8:    hex_to_seg = 7'b0000000;
      4'h9:    hex_to_seg = 7'b0000100;
      4'hA:    hex_to_seg = 7'b0001000;
      4'hB:    hex_to_seg = 7'b1100000;
      4'hC:    hex_to_seg = 7'b0110001;
      4'hD:    hex_to_seg = 7'b1000010;
      4'hE:    hex_to_seg = 7'b0110000;
      4'hF:    hex_to_seg = 7'b0111000;
      default: hex_to_seg = 7'b1111111;
    endcase
  endfunction

  generate
    if (GUARD > 0) begin : g_guard
      assign guard_s = (rcnt_r < RW'(GUARD));
    end else begin : g_no_guard
      assign guard_s = 1'b0;
    end
  endgenerate

  // Slot timing: refresh counter and scan index.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      rcnt_r <= '0;
      s_r    <= '0;
    end else if (rcnt_r == R_LAST) begin
      rcnt_r <= '0;
      s_r    <= (s_r == S_LAST) ? '0 : s_r + SW'(1);
    end else begin
      rcnt_r <= rcnt_r + RW'(1);
    end
  end

  // Free-running blink half-period counter and phase.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      bcnt_r  <= '0;
      phase_r <= 1'b0;
    end else if (bcnt_r == B_LAST) begin
      bcnt_r  <= '0;
      phase_r <= ~phase_r;
    end else begin
      bcnt_r  <= bcnt_r + BW'(1);
    end
  end

  // Select the active digit and decide whether its slot stays dark.
  always_comb begin
    sel_s = DIGITS'(1) << s_r;
    nib_s = 4'h0;
    nzd_s = '0;
    lz_s  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      nzd_s[i] = |digits[4*i +: 4];
      nib_s    = nib_s | (digits[4*i +: 4] & {4{sel_s[i]}});
    end
    // A digit is a leading zero when it and every digit above it are zero.
    for (int i = 1; i < DIGITS; i++) begin
      lz_s[i] = blank_lz & ~(|(nzd_s >> i));
    end
    dpi_s   = |(dp_in & sel_s);
    blank_s = guard_s | (|(lz_s & sel_s)) | (phase_r & (|(blink_mask & sel_s)));
  end

  // Registered pin drivers.
  always_ff @(posedge clk_100MHz) begin
    if (reset) begin
      an  <= {DIGITS{1'b1}};
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else if (blank_s) begin
      an  <= {DIGITS{1'b1}};
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= ~sel_s;
      seg <= hex_to_seg(nib_s);
      dp  <= ~dpi_s;
    end
  end

endmodule

// File: tb/tb_seg7_mux_n.sv
// Directed bench for seg7_mux_n: a 4-digit instance (REFRESH_DIV=8, GUARD=2, BLINK_DIV=40)
// and a 1-digit instance with no guard (REFRESH_DIV=4).
module tb_seg7_mux_n;

  localparam logic [6:0] S_0 = 7'b0000001, S_1 = 7'b1001111, S_2 = 7'b0010010, S_3 = 7'b0000110;
  localparam logic [6:0] S_4 = 7'b1001100, S_5 = 7'b0100100, S_6 = 7'b0100000, S_7 = 7'b0001111;
  localparam logic [6:0] S_8 = 7'b0000000, S_9 = 7'b0000100, S_A = 7'b0001000, S_B = 7'b1100000;
  localparam logic [6:0] S_C = 7'b0110001, S_D = 7'b1000010, S_E = 7'b0110000, S_F = 7'b0111000;
  localparam logic [6:0] BLK = 7'b1111111;
  localparam logic [11:0] DARK = {4'b1111, BLK, 1'b1};

  logic        clk_100MHz = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] digits = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_mask = 4'h0;
  logic [0:6]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [3:0]  digits_b = 4'h7;
  logic [0:6]  seg_b;
  logic        dp_b;
  logic [0:0]  an_b;

  int checks = 0;
  int errors = 0;
  int ecnt = 0;

  typedef struct {
    logic [15:0]     d;
    logic [3:0]      dpi;
    logic            lz;
    logic [3:0]      bm;
    logic [3:0]      lit;
    logic [3:0][6:0] segs;
    logic [3:0]      dpo;
  } vec_t;

  vec_t vecs[9];

  always #5 clk_100MHz = ~clk_100MHz;

  seg7_mux_n #(.DIGITS(4), .REFRESH_DIV(8), .GUARD(2), .BLINK_DIV(40)) dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .digits(digits), .dp_in(dp_in),
    .blank_lz(blank_lz), .blink_mask(blink_mask), .seg(seg), .dp(dp), .an(an)
  );

  seg7_mux_n #(.DIGITS(1), .REFRESH_DIV(4), .GUARD(0), .BLINK_DIV(40)) dut_b (
    .clk_100MHz(clk_100MHz), .reset(reset), .digits(digits_b), .dp_in(1'b0),
    .blank_lz(1'b0), .blink_mask(1'b0), .seg(seg_b), .dp(dp_b), .an(an_b)
  );

  task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: an/seg/dp got %b required %b", name, got, exp);
    end
  endtask

  // Advance to edge e after reset release and settle 1 time unit past it.
  task automatic step_to(input int e);
    while (ecnt < e) begin
      @(posedge clk_100MHz);
      ecnt++;
    end
    #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) @(posedge clk_100MHz);
    #1;
    chk("reset_state", {an, seg, dp}, DARK);
    reset = 1'b0;
    ecnt = 0;
  endtask

  function automatic logic [11:0] lit_exp(input int k, input logic [6:0] s, input logic d);
    logic [3:0] one;
    one = 4'b0001;
    return {~(one << k), s, d};
  endfunction

  initial begin
    vecs[0] = '{16'h1234, 4'b0000, 1'b0, 4'b0000, 4'b1111, {S_1, S_2, S_3, S_4}, 4'b1111};
    vecs[1] = '{16'hABCD, 4'b0000, 1'b0, 4'b0000, 4'b1111, {S_A, S_B, S_C, S_D}, 4'b1111};
    vecs[2] = '{16'hEF09, 4'b0000, 1'b0, 4'b0000, 4'b1111, {S_E, S_F, S_0, S_9}, 4'b1111};
    vecs[3] = '{16'h0045, 4'b0000, 1'b1, 4'b0000, 4'b0011, {BLK, BLK, S_4, S_5}, 4'b1111};
    vecs[4] = '{16'h0000, 4'b0000, 1'b1, 4'b0000, 4'b0001, {BLK, BLK, BLK, S_0}, 4'b1111};
    vecs[5] = '{16'h0405, 4'b0000, 1'b1, 4'b0000, 4'b0111, {BLK, S_4, S_0, S_5}, 4'b1111};
    vecs[6] = '{16'h0000, 4'b0000, 1'b0, 4'b0000, 4'b1111, {S_0, S_0, S_0, S_0}, 4'b1111};
    vecs[7] = '{16'h5678, 4'b0100, 1'b0, 4'b1000, 4'b1111, {S_5, S_6, S_7, S_8}, 4'b1011};
    vecs[8] = '{16'h1234, 4'b0000, 1'b1, 4'b0000, 4'b1111, {S_1, S_2, S_3, S_4}, 4'b1111};

    // Reset and scan: guard, slot length, frame period.
    digits = 16'h1234;
    do_reset(3);
    step_to(1);  chk("scan_e1_guard", {an, seg, dp}, DARK);
    step_to(2);  chk("scan_e2_guard", {an, seg, dp}, DARK);
    step_to(3);  chk("scan_e3_first", {an, seg, dp}, lit_exp(0, S_4, 1'b1));
    step_to(8);  chk("scan_e8_last", {an, seg, dp}, lit_exp(0, S_4, 1'b1));
    step_to(9);  chk("scan_e9_guard", {an, seg, dp}, DARK);
    step_to(11); chk("scan_e11_d1", {an, seg, dp}, lit_exp(1, S_3, 1'b1));
    step_to(34); chk("scan_e34_guard", {an, seg, dp}, DARK);
    step_to(35); chk("scan_e35_frame", {an, seg, dp}, lit_exp(0, S_4, 1'b1));

    // Table: each slot of frame 0 checked in its guard and at its first lit edge.
    for (int v = 0; v < 9; v++) begin
      digits = vecs[v].d;
      dp_in = vecs[v].dpi;
      blank_lz = vecs[v].lz;
      blink_mask = vecs[v].bm;
      do_reset(2);
      for (int k = 0; k < 4; k++) begin
        step_to(8*k + 2);
        chk($sformatf("vec%0d_slot%0d_guard", v, k), {an, seg, dp}, DARK);
        step_to(8*k + 3);
        if (vecs[v].lit[k])
          chk($sformatf("vec%0d_slot%0d", v, k), {an, seg, dp},
              lit_exp(k, vecs[v].segs[k], vecs[v].dpo[k]));
        else
          chk($sformatf("vec%0d_slot%0d", v, k), {an, seg, dp}, DARK);
      end
    end

    // Blink: phase is 1 for edges 41..80 and 0 for 81..120.
    digits = 16'h5678; dp_in = 4'b0100; blank_lz = 1'b0; blink_mask = 4'b1000;
    do_reset(2);
    step_to(43); chk("blink_d1_unmasked", {an, seg, dp}, lit_exp(1, S_7, 1'b1));
    step_to(51); chk("blink_d2_dp", {an, seg, dp}, lit_exp(2, S_6, 1'b0));
    step_to(59); chk("blink_d3_dark", {an, seg, dp}, DARK);
    step_to(64); chk("blink_d3_dark_end", {an, seg, dp}, DARK);
    step_to(91); chk("blink_d3_lit", {an, seg, dp}, lit_exp(3, S_5, 1'b1));

    // Reset mid-operation: edge 54 samples s=2, rcnt=5, phase=1.
    do_reset(2);
    step_to(53); chk("midrst_before", {an, seg, dp}, lit_exp(2, S_6, 1'b0));
    reset = 1'b1;
    blink_mask = 4'b1111;
    step_to(54); chk("midrst_reset_edge", {an, seg, dp}, DARK);
    reset = 1'b0;
    ecnt = 0;
    step_to(1); chk("midrst_e1_guard", {an, seg, dp}, DARK);
    step_to(2); chk("midrst_e2_guard", {an, seg, dp}, DARK);
    step_to(3); chk("midrst_e3_phase0", {an, seg, dp}, lit_exp(0, S_8, 1'b1));

    // Single digit, no guard.
    digits_b = 4'h7;
    do_reset(2);
    chk("one_reset", {3'b111, an_b, seg_b, dp_b}, DARK);
    for (int e = 1; e <= 8; e++) begin
      step_to(e);
      chk($sformatf("one_e%0d", e), {3'b111, an_b, seg_b, dp_b}, {4'b1110, S_7, 1'b1});
    end
    digits_b = 4'h8;
    #1 chk("one_hold", {3'b111, an_b, seg_b, dp_b}, {4'b1110, S_7, 1'b1});
    step_to(9);
    chk("one_latency", {3'b111, an_b, seg_b, dp_b}, {4'b1110, S_8, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
